// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter needs at least one bit even when a single RUN cycle suffices.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/serial_digit_add.sv
// Combinational DIGIT-bit adder slice; cmsb is the carry into the top bit,
// which the overflow option compares against the carry out.
module serial_digit_add #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [DIGIT:0] sum;

  assign sum  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  assign s    = sum[DIGIT-1:0];
  assign co   = sum[DIGIT];
  // Sum bit = x ^ y ^ carry-in, so the carry into the MSB falls out directly.
  assign cmsb = x[DIGIT-1] ^ y[DIGIT-1] ^ sum[DIGIT-1];

endmodule

// File: rtl/serial_addsub_p.sv
// Multi-cycle serial add/sub, DIGIT bits per cycle LSB first, valid/ready on
// both sides. Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module serial_addsub_p
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg, res_nxt;
  logic [CW-1:0]    count;
  logic             carry;
  logic [DIGIT-1:0] d;
  logic             c, cmsb;

  serial_digit_add #(.DIGIT(DIGIT)) u_digit (
    .x   (a_reg[DIGIT-1:0]),
    .y   (b_reg[DIGIT-1:0]),
    .ci  (carry),
    .s   (d),
    .co  (c),
    .cmsb(cmsb)
  );

  // New digit enters at the top; a full-width digit replaces res outright.
  generate
    if (DIGIT == WIDTH) begin : g_whole
      assign res_nxt = d;
    end else begin : g_shift
      assign res_nxt = {d, res[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign cout = carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res       <= '0;
      count     <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction as A + ~B + ~borrow.
            a_reg    <= a;
            b_reg    <= sub ? ~b : b;
            carry    <= cin ^ sub;
            res      <= '0;
            count    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf      <= 1'b0;
`endif
          end
        end
        RUN: begin
          res   <= res_nxt;
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          carry <= c;
          count <= count + 1'b1;
          if (count == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf       <= c ^ cmsb;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
